dl11_fifo_regs: RTL and testbench

Parametrised DL11-compatible console/serial register block with receive and transmit FIFOs, configurable I/O-page base address and interrupt vector. It sits on the CPU I/O page and presents the four standard DL11 registers: RCSR, RBUF, XCSR and XBUF. On the other side it exchanges bytes with a serial byte engine (baud generator plus shifter) through valid/ready handshakes. Multiple instances with different bases and vectors provide additional serial lines.

---
 rtl/dl11_fifo_regs_if.sv | 48 ++++
 rtl/dl11_fifo_regs.sv | 192 +++++++++++++++++++
 tb/tb_dl11_fifo_regs.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dl11_fifo_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : dl11_fifo_regs_if
// Purpose  : Bundles the I/O-page bus and serial byte-engine handshakes of a
//            DL11-style register block.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   iopage_addr[12:0], data_in[15:0], iopage_rd, iopage_wr, iopage_byte_op,
//   interrupt_ack                           : CPU -> register block
//   data_out[15:0], decode, interrupt,
//   vector[7:0]                             : register block -> CPU
//   tx_data[7:0], tx_valid / tx_ready       : transmit byte handshake
//   rx_data[7:0], rx_valid                  : receive byte strobe
// Modports:
//   slave  : the register block
//   master : the CPU / serial-engine side
// ============================================================================
interface dl11_fifo_regs_if;
  logic [12:0] iopage_addr;
  logic [15:0] data_in;
  logic        iopage_rd;
  logic        iopage_wr;
  logic        iopage_byte_op;
  logic [15:0] data_out;
  logic        decode;
  logic        interrupt;
  logic        interrupt_ack;
  logic [7:0]  vector;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  modport slave (
    input  iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op,
    input  interrupt_ack, tx_ready, rx_data, rx_valid,
    output data_out, decode, interrupt, vector, tx_data, tx_valid
  );

  modport master (
    output iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op,
    output interrupt_ack, tx_ready, rx_data, rx_valid,
    input  data_out, decode, interrupt, vector, tx_data, tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/dl11_fifo_regs.sv
`default_nettype none
// ============================================================================
// Module   : dl11_fifo_regs
// Purpose  : DL11-compatible serial line register block (RCSR, RBUF, XCSR,
//            XBUF) with receive and transmit byte FIFOs and interrupts.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   BASE_ADDR     : I/O-page address of RCSR (RBUF +2, XCSR +4, XBUF +6)
//   VECTOR        : receive vector; transmit vector is VECTOR+4
//   RX_DEPTH_LOG2 : log2 of receive FIFO depth (>= 1)
//   TX_DEPTH_LOG2 : log2 of transmit FIFO depth (>= 1)
// Ports:
//   clk   : single clock
//   reset : synchronous, active-high reset
//   bus   : dl11_fifo_regs_if.slave (I/O-page bus + serial handshakes)
// Build option:
//   DL11_RX_OVERRUN_EN : adds a sticky receive-overrun flag on RBUF[15:14]
// ============================================================================
module dl11_fifo_regs #(
  parameter logic [12:0] BASE_ADDR     = 13'o17560,
  parameter logic [7:0]  VECTOR        = 8'o60,
  parameter int          RX_DEPTH_LOG2 = 4,
  parameter int          TX_DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           reset,
  dl11_fifo_regs_if.slave bus
);

  localparam int c_rx_depth = 2 ** RX_DEPTH_LOG2;
  localparam int c_tx_depth = 2 ** TX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] c_rx_one = (RX_DEPTH_LOG2+1)'(1);
  localparam logic [TX_DEPTH_LOG2:0] c_tx_one = (TX_DEPTH_LOG2+1)'(1);

  // ---------------------------------------------------------------- state
  logic [7:0]             r_rx_mem [c_rx_depth];
  logic [7:0]             r_tx_mem [c_tx_depth];
  logic [RX_DEPTH_LOG2:0] r_rx_wptr, r_rx_rptr;
  logic [TX_DEPTH_LOG2:0] r_tx_wptr, r_tx_rptr;
  logic                   r_rd_q;
  logic                   r_rie, r_tie;
  logic [7:0]             r_xbuf;
  logic                   r_rx_cond_q, r_tx_cond_q;
  logic                   r_rx_pend, r_tx_pend;
  logic                   r_interrupt;

  // --------------------------------------------------------- address decode
  logic w_sel_rcsr, w_sel_rbuf, w_sel_xcsr, w_sel_xbuf;
  assign w_sel_rcsr = (bus.iopage_addr == BASE_ADDR);
  assign w_sel_rbuf = (bus.iopage_addr == BASE_ADDR + 13'd2);
  assign w_sel_xcsr = (bus.iopage_addr == BASE_ADDR + 13'd4);
  assign w_sel_xbuf = (bus.iopage_addr == BASE_ADDR + 13'd6);
  assign bus.decode = w_sel_rcsr | w_sel_rbuf | w_sel_xcsr | w_sel_xbuf;

  logic w_rd_rise, w_rcsr_wr, w_xcsr_wr, w_xbuf_wr;
  assign w_rd_rise = bus.iopage_rd && !r_rd_q;
  assign w_rcsr_wr = bus.iopage_wr && w_sel_rcsr;
  assign w_xcsr_wr = bus.iopage_wr && w_sel_xcsr;
  assign w_xbuf_wr = bus.iopage_wr && w_sel_xbuf;

  // ------------------------------------------------------------- RX FIFO
  logic       w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_drains;
  logic [7:0] w_rx_head;
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[RX_DEPTH_LOG2] != r_rx_rptr[RX_DEPTH_LOG2]) &&
                      (r_rx_wptr[RX_DEPTH_LOG2-1:0] == r_rx_rptr[RX_DEPTH_LOG2-1:0]);
  // Only the leading cycle of a (possibly long) RBUF read strobe pops.
  assign w_rx_pop   = w_sel_rbuf && w_rd_rise && !w_rx_empty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign w_rx_push  = bus.rx_valid && (!w_rx_full || w_rx_pop);
  assign w_rx_head  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[RX_DEPTH_LOG2-1:0]];
  // This pop takes the last byte and nothing refills it this cycle.
  assign w_rx_drains = w_rx_pop && !w_rx_push && ((r_rx_rptr + c_rx_one) == r_rx_wptr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_rx_one;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_rx_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[RX_DEPTH_LOG2-1:0]] <= bus.rx_data;
  end

  // ------------------------------------------------------------- TX FIFO
  logic w_tx_empty, w_tx_full, w_tx_pop, w_tx_push;
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[TX_DEPTH_LOG2] != r_tx_rptr[TX_DEPTH_LOG2]) &&
                      (r_tx_wptr[TX_DEPTH_LOG2-1:0] == r_tx_rptr[TX_DEPTH_LOG2-1:0]);
  assign w_tx_pop   = !w_tx_empty && bus.tx_ready;
  assign w_tx_push  = w_xbuf_wr && (!w_tx_full || w_tx_pop);
  assign bus.tx_valid = !w_tx_empty;
  assign bus.tx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr[TX_DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_tx_one;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_tx_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[TX_DEPTH_LOG2-1:0]] <= bus.data_in[7:0];
  end

  // -------------------------------------------------------- overrun flag
  logic [1:0] w_rbuf_hi;
`ifdef DL11_RX_OVERRUN_EN
  logic r_overrun;
  always_ff @(posedge clk) begin
    if (reset)                                  r_overrun <= 1'b0;
    else if (w_rx_pop)                          r_overrun <= 1'b0;
    else if (bus.rx_valid && w_rx_full)         r_overrun <= 1'b1;
  end
  // bit15 = error summary, bit14 = overrun; overrun is the only error source
  assign w_rbuf_hi = {r_overrun, r_overrun};
`else
  assign w_rbuf_hi = 2'b00;
`endif

  // ------------------------------------------------- control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_q <= 1'b0;
      r_rie  <= 1'b0;
      r_tie  <= 1'b0;
      r_xbuf <= 8'h00;
    end else begin
      r_rd_q <= bus.iopage_rd;
      if (w_rcsr_wr) r_rie  <= bus.data_in[6];
      if (w_xcsr_wr) r_tie  <= bus.data_in[6];
      if (w_xbuf_wr) r_xbuf <= bus.data_in[7:0];
    end
  end

  // ----------------------------------------------------------- interrupts
  logic w_rx_cond, w_tx_cond, w_rx_set, w_tx_set, w_rx_clr, w_tx_clr;
  assign w_rx_cond = r_rie && !w_rx_empty;
  assign w_tx_cond = r_tie && !w_tx_full;
  assign w_rx_set  = w_rx_cond && !r_rx_cond_q;
  assign w_tx_set  = w_tx_cond && !r_tx_cond_q;
  // An ack applies only to the vector being presented (RX has priority).
  assign w_rx_clr  = (bus.interrupt_ack && r_rx_pend) ||
                     (w_rcsr_wr && !bus.data_in[6]) || w_rx_drains;
  assign w_tx_clr  = (bus.interrupt_ack && !r_rx_pend && r_tx_pend) ||
                     (w_xcsr_wr && !bus.data_in[6]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_cond_q <= 1'b0;
      r_tx_cond_q <= 1'b0;
      r_rx_pend   <= 1'b0;
      r_tx_pend   <= 1'b0;
      r_interrupt <= 1'b0;
    end else begin
      r_rx_cond_q <= w_rx_cond;
      r_tx_cond_q <= w_tx_cond;
      r_rx_pend   <= (r_rx_pend | w_rx_set) & ~w_rx_clr;
      r_tx_pend   <= (r_tx_pend | w_tx_set) & ~w_tx_clr;
      r_interrupt <= r_rx_pend | r_tx_pend;
    end
  end

  assign bus.interrupt = r_interrupt;
  assign bus.vector    = r_rx_pend ? VECTOR :
                         r_tx_pend ? (VECTOR + 8'd4) : 8'h00;

  // ------------------------------------------------------------ read mux
  always_comb begin
    bus.data_out = 16'h0000;
    if (bus.iopage_rd) begin
      if (w_sel_rcsr) bus.data_out = {8'h00, !w_rx_empty, r_rie, 6'b000000};
      if (w_sel_rbuf) bus.data_out = {w_rbuf_hi, 6'b000000, w_rx_head};
      if (w_sel_xcsr) bus.data_out = {8'h00, !w_tx_full, r_tie, 6'b000000};
      if (w_sel_xbuf) bus.data_out = {8'h00, r_xbuf};
    end
  end

  // Registers are byte-wide, so the high data byte and byte_op carry no state.
  logic w_unused;
  assign w_unused = ^{bus.iopage_byte_op, bus.data_in[15:8]};

endmodule
`default_nettype wire

// File: tb/tb_dl11_fifo_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_dl11_fifo_regs
// Purpose  : Self-checking bench for dl11_fifo_regs: reset/register table,
//            TX drain and full FIFO, held RBUF read, interrupt priority,
//            receive overrun (DL11_RX_OVERRUN_EN aware) and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dl11_fifo_regs;

  localparam logic [12:0] c_base   = 13'o17560;
  localparam logic [12:0] c_a_rcsr = c_base;
  localparam logic [12:0] c_a_rbuf = c_base + 13'd2;
  localparam logic [12:0] c_a_xcsr = c_base + 13'd4;
  localparam logic [12:0] c_a_xbuf = c_base + 13'd6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dl11_fifo_regs_if bus ();

  dl11_fifo_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [12:0] addr;
    logic        rd;
    logic [15:0] exp_data;
    logic        exp_dec;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [12:0] a, input logic [15:0] d);
    bus.iopage_addr = a;
    bus.data_in     = d;
    bus.iopage_wr   = 1'b1;
    cyc();
    bus.iopage_wr   = 1'b0;
    #1;
  endtask

  task automatic rd(input logic [12:0] a, output logic [15:0] d);
    bus.iopage_addr = a;
    bus.iopage_rd   = 1'b1;
    #1;
    d = bus.data_out;
    cyc();
    bus.iopage_rd   = 1'b0;
    cyc();
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    cyc();
    bus.rx_valid = 1'b0;
    #1;
  endtask

  logic [15:0] d;

  initial begin
    bus.iopage_addr    = '0;
    bus.data_in        = '0;
    bus.iopage_rd      = 1'b0;
    bus.iopage_wr      = 1'b0;
    bus.iopage_byte_op = 1'b0;
    bus.interrupt_ack  = 1'b0;
    bus.tx_ready       = 1'b0;
    bus.rx_data        = '0;
    bus.rx_valid       = 1'b0;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    #1;

    // ---------------- reset state and address decode (table driven)
    vecs[0] = '{c_a_rcsr,          1'b1, 16'h0000, 1'b1};
    vecs[1] = '{c_a_rbuf,          1'b1, 16'h0000, 1'b1};
    vecs[2] = '{c_a_xcsr,          1'b1, 16'h0080, 1'b1};
    vecs[3] = '{c_a_xbuf,          1'b1, 16'h0000, 1'b1};
    vecs[4] = '{c_a_xcsr,          1'b0, 16'h0000, 1'b1};
    vecs[5] = '{c_base - 13'd2,    1'b1, 16'h0000, 1'b0};
    vecs[6] = '{c_base + 13'd8,    1'b1, 16'h0000, 1'b0};
    vecs[7] = '{c_base + 13'd1,    1'b1, 16'h0000, 1'b0};

    check("rst_interrupt", {15'd0, bus.interrupt}, 16'd0);
    check("rst_vector",    {8'd0, bus.vector},     16'd0);
    check("rst_tx_valid",  {15'd0, bus.tx_valid},  16'd0);
    check("rst_tx_data",   {8'd0, bus.tx_data},    16'd0);
    check("rst_data_out",  bus.data_out,           16'd0);

    for (int i = 0; i < 8; i++) begin
      bus.iopage_addr = vecs[i].addr;
      bus.iopage_rd   = vecs[i].rd;
      #1;
      check($sformatf("tbl%0d_data", i), bus.data_out, vecs[i].exp_data);
      check($sformatf("tbl%0d_decode", i), {15'd0, bus.decode}, {15'd0, vecs[i].exp_dec});
      cyc();
      bus.iopage_rd = 1'b0;
      cyc();
    end

    // ---------------- TX: two bytes, then drain
    wr(c_a_xbuf, 16'h0041);
    check("tx_valid_after_wr", {15'd0, bus.tx_valid}, 16'd1);
    check("tx_data_head",      {8'd0, bus.tx_data},   16'h0041);
    wr(c_a_xbuf, 16'h0042);
    rd(c_a_xbuf, d);
    check("xbuf_readback", d, 16'h0042);
    bus.tx_ready = 1'b1;
    check("tx_drain0", {8'd0, bus.tx_data}, 16'h0041);
    cyc();
    check("tx_drain1", {8'd0, bus.tx_data}, 16'h0042);
    cyc();
    bus.tx_ready = 1'b0;
    check("tx_empty", {15'd0, bus.tx_valid}, 16'd0);

    // ---------------- TX: fill to 16, drop 17th
    for (int i = 0; i < 16; i++) wr(c_a_xbuf, 16'h0060 + 16'(i));
    rd(c_a_xcsr, d);
    check("xcsr_full", d, 16'h0000);
    wr(c_a_xbuf, 16'h00EE);
    bus.tx_ready = 1'b1;
    check("full_head", {8'd0, bus.tx_data}, 16'h0060);
    cyc();
    bus.tx_ready = 1'b0;
    rd(c_a_xcsr, d);
    check("xcsr_after_drain", d, 16'h0080);
    bus.tx_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fill_drain%0d", i), {8'd0, bus.tx_data}, 16'h0060 + 16'(i));
      cyc();
    end
    bus.tx_ready = 1'b0;
    check("dropped_17th", {15'd0, bus.tx_valid}, 16'd0);

    // ---------------- RX: held read pops once
    rx_byte(8'h31);
    rx_byte(8'h32);
    rd(c_a_rcsr, d);
    check("rcsr_done", d, 16'h0080);
    bus.iopage_addr = c_a_rbuf;
    bus.iopage_rd   = 1'b1;
    #1;
    check("held_rd_first", bus.data_out, 16'h0031);
    cyc();
    check("held_rd_c2", bus.data_out, 16'h0032);
    cyc();
    cyc();
    check("held_rd_c4", bus.data_out, 16'h0032);
    bus.iopage_rd = 1'b0;
    cyc();
    rd(c_a_rbuf, d);
    check("rbuf_second", d, 16'h0032);
    rd(c_a_rcsr, d);
    check("rcsr_empty", d, 16'h0000);
    rd(c_a_rbuf, d);
    check("rbuf_empty", d, 16'h0000);

    // ---------------- RX interrupt and ack timing
    wr(c_a_rcsr, 16'h0040);
    rd(c_a_rcsr, d);
    check("rcsr_rie", d, 16'h0040);
    rx_byte(8'h55);
    check("irq_vec_early", {8'd0, bus.vector}, 16'h0000);
    cyc();
    check("irq_vec_rx",    {8'd0, bus.vector},    16'h0030);
    check("irq_not_yet",   {15'd0, bus.interrupt}, 16'd0);
    cyc();
    check("irq_raised",    {15'd0, bus.interrupt}, 16'd1);
    bus.interrupt_ack = 1'b1;
    cyc();
    bus.interrupt_ack = 1'b0;
    #1;
    check("ack_vec_cleared", {8'd0, bus.vector},    16'h0000);
    check("ack_irq_lag",     {15'd0, bus.interrupt}, 16'd1);
    cyc();
    check("ack_irq_low",     {15'd0, bus.interrupt}, 16'd0);

    // ---------------- RX and TX pending together: RX first
    rd(c_a_rbuf, d);
    check("rbuf_55", d, 16'h0055);
    bus.rx_data     = 8'h66;
    bus.rx_valid    = 1'b1;
    bus.iopage_addr = c_a_xcsr;
    bus.data_in     = 16'h0040;
    bus.iopage_wr   = 1'b1;
    cyc();
    bus.rx_valid  = 1'b0;
    bus.iopage_wr = 1'b0;
    #1;
    cyc();
    check("prio_rx_first", {8'd0, bus.vector}, 16'h0030);
    cyc();
    check("prio_irq", {15'd0, bus.interrupt}, 16'd1);
    bus.interrupt_ack = 1'b1;
    cyc();
    bus.interrupt_ack = 1'b0;
    #1;
    check("prio_tx_next", {8'd0, bus.vector}, 16'h0034);
    cyc();
    check("prio_irq_held", {15'd0, bus.interrupt}, 16'd1);
    bus.interrupt_ack = 1'b1;
    cyc();
    bus.interrupt_ack = 1'b0;
    #1;
    check("prio_none", {8'd0, bus.vector}, 16'h0000);
    cyc();
    check("prio_irq_low", {15'd0, bus.interrupt}, 16'd0);

    // ---------------- TIE re-enable raises, TIE=0 clears
    wr(c_a_xcsr, 16'h0000);
    wr(c_a_xcsr, 16'h0040);
    cyc();
    check("tie_rearm", {8'd0, bus.vector}, 16'h0034);
    wr(c_a_xcsr, 16'h0000);
    check("tie_clear", {8'd0, bus.vector}, 16'h0000);
    rd(c_a_rbuf, d);
    check("rbuf_66", d, 16'h0066);
    wr(c_a_rcsr, 16'h0000);

    // ---------------- RX overrun: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) rx_byte(8'h80 + 8'(i));
    rd(c_a_rbuf, d);
`ifdef DL11_RX_OVERRUN_EN
    check("ovr_first", d, 16'hC080);
`else
    check("ovr_first", d, 16'h0080);
`endif
    rd(c_a_rbuf, d);
    check("ovr_second", d, 16'h0081);

    // ---------------- reset mid-operation
    wr(c_a_xbuf, 16'h0077);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("mid_rst_tx_valid", {15'd0, bus.tx_valid}, 16'd0);
    rd(c_a_rcsr, d);
    check("mid_rst_rcsr", d, 16'h0000);
    rd(c_a_xbuf, d);
    check("mid_rst_xbuf", d, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
